imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Parametrised, pipelined immediate generator. Successor to the combinational immediate extender.
- Takes {instruction, ext-op, tag} over a valid/ready handshake and returns the sign-extended immediate, an illegal-format flag and the tag.
- Generalised to XLEN 32/64 and to RVC immediate formats.
- Sits between the decoder and the ID/EX register. A 2-entry skid buffer gives full throughput while keeping in_ready registered.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- RVC_EN, 1, when 1 the CI/CB/CJ formats are legal; when 0 they are illegal.
- TAG_W, 32, width of the opaque sideband (typically PC) carried alongside.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input request valid.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  instruction word (RVC uses [15:0]).
- in_extop  in  4  format selector (package constants).
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_illegal  out  1  in_extop unsupported.
- out_tag  out  TAG_W  sideband, aligned with out_imm.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous, active-high, sampled on the rising edge.
  - Reset values: out_valid=0, in_ready=1, out_imm=0, out_illegal=0, out_tag=0; both buffer entries empty.
- Format decode (combinational on input; result captured at acceptance). Every result is sign-extended from its top bit to XLEN.
  - I=0: {inst[31:20]}
  - U=1: {inst[31:12], 12'b0}; for XLEN=64, bit 31 is replicated into [63:32].
  - S=2: {inst[31:25], inst[11:7]}
  - B=3: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J=4: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - CI=5: {inst[12], inst[6:2]}
  - CB=6: {inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 0}
  - CJ=7: {inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 0}
  - Codes 8..15, or 5..7 with RVC_EN=0: imm=0 and illegal=1.
- Handshake:
  - Transfer occurs on valid&ready, at both input and output.
  - Latency is 1 cycle: an item accepted in cycle N is presented on out_* in cycle N+1 at the earliest.
  - Throughput is one item per cycle while out_ready=1.
  - out_* must hold stable while out_valid=1 and out_ready=0.
  - Order is strictly FIFO.
- Skid buffer:
  - Main register M drives out_*; skid register K holds overflow.
  - in_ready = K empty (registered).
  - Input accepted while M is full and the output is not consumed: the item goes to K and in_ready becomes 0 next cycle.
  - Output consumed while K is full: K moves to M, K empties, in_ready becomes 1 next cycle.
  - Simultaneous accept and consume with K empty: the new item loads M directly.
  - K full implies M full; the bench asserts this invariant.
  - Never drop or duplicate an item.
- Flush:
  - Clears M and K valid bits in the same edge; out_valid=0 and in_ready=1 next cycle.
  - An input presented in the flush cycle is discarded.
  - Flush has priority over accept and consume. rst has priority over flush.
- Reset mid-operation: all buffered items are discarded and outputs return to reset values on the next edge.
- Data registers need not be cleared by flush, only the valid bits.

Decomposition:
- Shared package holds:
  - EXT_OP_W=4 and the EXT_OP_I/U/S/B/J/CI/CB/CJ codes.
  - XLEN legal values.
  - Record typedef {imm, illegal, tag} used for both M and K.
- One natural sub-module: imm_decode. It is purely combinational (inst, extop → imm, illegal), parametrised on XLEN and RVC_EN, and reusable by the decoder.
- Skid buffer logic stays in imm_gen_stage.

Test Plan:
- XLEN=32, I, inst=0xFFF00093, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, illegal=0, tag echoed.
- XLEN=32, B, inst=0xFE000EE3 → out_imm=0xFFFFFFFC. XLEN=64, U, inst=0x800000B7 → out_imm=0xFFFFFFFF80000000.
- RVC_EN=1, CI, inst=0x000050FD → out_imm=all ones. Same stimulus with RVC_EN=0 → out_imm=0, illegal=1. extop=0xA → out_imm=0, illegal=1.
- Backpressure: out_ready=0; push tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted.
  - in_ready=0 from the cycle after the 2nd accept, so tag 3 is held.
  - Raise out_ready: tags 1, 2, 3 emerge in order with no bubble after the first; out_* stable during the stall.
- Stream 100 random items with random out_ready → scoreboard matches a reference decode, with no loss, duplication or reordering.
- Flush or rst asserted with both entries full → out_valid=0 and in_ready=1 next cycle. An item offered in the flush cycle never appears at the output.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared constants for the immediate generator stage.
// Holds ext-op codes, legal XLEN values and a width helper.
package imm_gen_stage_pkg;

  localparam int EXT_OP_W = 4;

  localparam logic [EXT_OP_W-1:0] EXT_OP_I  = 4'd0;
  localparam logic [EXT_OP_W-1:0] EXT_OP_U  = 4'd1;
  localparam logic [EXT_OP_W-1:0] EXT_OP_S  = 4'd2;
  localparam logic [EXT_OP_W-1:0] EXT_OP_B  = 4'd3;
  localparam logic [EXT_OP_W-1:0] EXT_OP_J  = 4'd4;
  localparam logic [EXT_OP_W-1:0] EXT_OP_CI = 4'd5;
  localparam logic [EXT_OP_W-1:0] EXT_OP_CB = 4'd6;
  localparam logic [EXT_OP_W-1:0] EXT_OP_CJ = 4'd7;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  function automatic bit xlenLegal(int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decode: inst, extop -> imm, illegal.
// Ports: inst[31:0], extop[3:0] in; imm[XLEN-1:0], illegal out.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic [31:0]         inst,
  input  logic [EXT_OP_W-1:0] extop,
  output logic [XLEN-1:0]     imm,
  output logic                illegal
);

  logic [31:0] imm32;
  logic        isI, isU, isS, isB, isJ;
  logic        isCi, isCb, isCj;
  logic [1:0]  unusedBits;

  // Opcode bits [1:0] never carry immediate data.
  assign unusedBits = inst[1:0];

  assign isI  = (extop == EXT_OP_I);
  assign isU  = (extop == EXT_OP_U);
  assign isS  = (extop == EXT_OP_S);
  assign isB  = (extop == EXT_OP_B);
  assign isJ  = (extop == EXT_OP_J);
  assign isCi = RVC_EN && (extop == EXT_OP_CI);
  assign isCb = RVC_EN && (extop == EXT_OP_CB);
  assign isCj = RVC_EN && (extop == EXT_OP_CJ);

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    unique case (1'b1)
      isI: imm32 = {{20{inst[31]}}, inst[31:20]};
      isU: imm32 = {inst[31:12], 12'b0};
      isS: imm32 = {{20{inst[31]}}, inst[31:25],
                    inst[11:7]};
      isB: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      isJ: imm32 = {{11{inst[31]}}, inst[31],
                    inst[19:12], inst[20],
                    inst[30:21], 1'b0};
      isCi: imm32 = {{26{inst[12]}}, inst[12],
                     inst[6:2]};
      isCb: imm32 = {{23{inst[12]}}, inst[12],
                     inst[6:5], inst[2], inst[11:10],
                     inst[4:3], 1'b0};
      isCj: imm32 = {{20{inst[12]}}, inst[12], inst[8],
                     inst[10:9], inst[6], inst[7],
                     inst[2], inst[11], inst[5:3],
                     1'b0};
      default: illegal = 1'b1;
    endcase
  end

  // All formats are at most 32 bits wide; widen by sign.
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with a 2-entry skid buffer.
// Ports: clk, rst, flush; in_* request; out_* result handshake.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1,
  parameter int TAG_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [EXT_OP_W-1:0] in_extop,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rec_t;

  logic [XLEN-1:0] decImm;
  logic            decIllegal;
  rec_t            inRec;
  rec_t            mRec, mRecNxt;
  rec_t            kRec, kRecNxt;
  logic            mValid, mValidNxt;
  logic            kValid, kValidNxt;
  logic            accept, consume;

  imm_decode #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) uDecode (
    .inst    (in_inst),
    .extop   (in_extop),
    .imm     (decImm),
    .illegal (decIllegal)
  );

  assign inRec.imm     = decImm;
  assign inRec.illegal = decIllegal;
  assign inRec.tag     = in_tag;

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready = ~kValid;
  assign accept   = in_valid & in_ready;
  assign consume  = mValid & out_ready;

  always_comb begin
    mValidNxt = mValid;
    kValidNxt = kValid;
    mRecNxt   = mRec;
    kRecNxt   = kRec;
    if (flush) begin
      mValidNxt = 1'b0;
      kValidNxt = 1'b0;
    end else if (consume) begin
      if (kValid) begin
        mRecNxt   = kRec;
        kValidNxt = 1'b0;
      end else if (accept) begin
        mRecNxt = inRec;
      end else begin
        mValidNxt = 1'b0;
      end
    end else if (accept) begin
      if (mValid) begin
        kRecNxt   = inRec;
        kValidNxt = 1'b1;
      end else begin
        mRecNxt   = inRec;
        mValidNxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mValid <= 1'b0;
      kValid <= 1'b0;
      mRec   <= '0;
      kRec   <= '0;
    end else begin
      mValid <= mValidNxt;
      kValid <= kValidNxt;
      mRec   <= mRecNxt;
      kRec   <= kRecNxt;
    end
  end

  assign out_valid   = mValid;
  assign out_imm     = mRec.imm;
  assign out_illegal = mRec.illegal;
  assign out_tag     = mRec.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage (32-bit RVC and 64-bit no-RVC).
// Both instances share stimulus and must stay in lockstep.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0] imm32;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  op;
    logic [31:0] imm32;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady;
  logic [31:0] inInst, inTag;
  logic [3:0]  inExtop;
  logic        rdy32, ov32, ill32o;
  logic [31:0] imm32o, tag32o;
  logic        rdy64, ov64, ill64o;
  logic [63:0] imm64o;
  logic [31:0] tag64o;

  int   checks = 0;
  int   failures = 0;
  bit   randReady = 0;
  exp_t q[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .RVC_EN(1'b1), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(rdy32),
    .in_inst(inInst), .in_extop(inExtop), .in_tag(inTag),
    .out_valid(ov32), .out_ready(outReady),
    .out_imm(imm32o), .out_illegal(ill32o), .out_tag(tag32o)
  );

  imm_gen_stage #(.XLEN(64), .RVC_EN(1'b0), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(rdy64),
    .in_inst(inInst), .in_extop(inExtop), .in_tag(inTag),
    .out_valid(ov64), .out_ready(outReady),
    .out_imm(imm64o), .out_illegal(ill64o), .out_tag(tag64o)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference decode built from shifts of the sign-extended word.
  function automatic logic [64:0] refDecode(logic [31:0] inst,
                                            logic [3:0] op,
                                            bit rvc);
    logic signed [63:0] s;
    logic [63:0] t, c, r;
    logic ill;
    s = $signed({{32{inst[31]}}, inst});
    c = {64{inst[12]}};
    r = '0;
    ill = 1'b0;
    case (op)
      4'd0: begin t = s >>> 20; r = t; end
      4'd1: begin t = s >>> 12; r = t << 12; end
      4'd2: begin
        t = s >>> 25;
        r = (t << 5) | 64'(inst[11:7]);
      end
      4'd3: begin
        t = s >>> 31;
        r = (t << 12) | (64'(inst[7]) << 11)
          | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
      end
      4'd4: begin
        t = s >>> 31;
        r = (t << 20) | (64'(inst[19:12]) << 12)
          | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
      end
      4'd5: if (rvc) r = (c << 5) | 64'(inst[6:2]);
            else ill = 1'b1;
      4'd6: if (rvc)
              r = (c << 8) | (64'(inst[6:5]) << 6)
                | (64'(inst[2]) << 5) | (64'(inst[11:10]) << 3)
                | (64'(inst[4:3]) << 1);
            else ill = 1'b1;
      4'd7: if (rvc)
              r = (c << 11) | (64'(inst[8]) << 10)
                | (64'(inst[10:9]) << 8) | (64'(inst[6]) << 7)
                | (64'(inst[7]) << 6) | (64'(inst[2]) << 5)
                | (64'(inst[11]) << 4) | (64'(inst[5:3]) << 1);
            else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic exp_t mkExp(int i, logic [31:0] tag);
    exp_t e;
    e.imm32 = vecs[i].imm32;
    e.ill32 = vecs[i].ill32;
    e.imm64 = vecs[i].imm64;
    e.ill64 = vecs[i].ill64;
    e.tag   = tag;
    return e;
  endfunction

  // Offer one item; expectation is queued on the accepting cycle.
  task automatic send(logic [31:0] inst, logic [3:0] op,
                      logic [31:0] tag, exp_t e);
    bit ok = 0;
    inValid = 1'b1;
    inInst  = inst;
    inExtop = op;
    inTag   = tag;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rdy32) begin
        if (!flush) q.push_back(e);
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept tag=%h", tag);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic sendVec(int i, logic [31:0] tag);
    send(vecs[i].inst, vecs[i].op, tag, mkExp(i, tag));
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every output transfer.
  bit          stallPrev = 0;
  logic [31:0] stImm32, stTag;
  logic [63:0] stImm64;

  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (stallPrev && ov32) begin
        chk("stall_imm32", imm32o, stImm32);
        chk("stall_tag", tag32o, stTag);
        chk("stall_imm64", imm64o, stImm64);
      end
      if (ov32 && outReady) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual=tag %h required=none", tag32o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_ov64", ov64, 1'b1);
          chk("sb_imm32", imm32o, e.imm32);
          chk("sb_ill32", ill32o, e.ill32);
          chk("sb_tag32", tag32o, e.tag);
          chk("sb_imm64", imm64o, e.imm64);
          chk("sb_ill64", ill64o, e.ill64);
          chk("sb_tag64", tag64o, e.tag);
        end
      end
      stallPrev = ov32 && !outReady;
      stImm32 = imm32o;
      stTag   = tag32o;
      stImm64 = imm64o;
    end else begin
      stallPrev = 0;
    end
  end

  always @(negedge clk) begin
    if (dut32.kValid) chk("k_implies_m", dut32.mValid, 1'b1);
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      if (randReady) outReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hFFF00093, 4'h0, 32'hFFFFFFFF, 1'b0,
                64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 4'h3, 32'hFFFFFFFC, 1'b0,
                64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'h800000B7, 4'h1, 32'h80000000, 1'b0,
                64'hFFFFFFFF80000000, 1'b0};
    vecs[3] = '{32'h000050FD, 4'h5, 32'hFFFFFFFF, 1'b0,
                64'h0, 1'b1};
    vecs[4] = '{32'h000050FD, 4'hA, 32'h0, 1'b1,
                64'h0, 1'b1};
    vecs[5] = '{32'h00112623, 4'h2, 32'h0000000C, 1'b0,
                64'h000000000000000C, 1'b0};
    vecs[6] = '{32'h0080006F, 4'h4, 32'h00000008, 1'b0,
                64'h0000000000000008, 1'b0};
    vecs[7] = '{32'h0000D001, 4'h6, 32'hFFFFFF00, 1'b0,
                64'h0, 1'b1};
    vecs[8] = '{32'h0000A011, 4'h7, 32'h00000004, 1'b0,
                64'h0, 1'b1};

    rst = 1'b1; flush = 1'b0; inValid = 1'b0;
    outReady = 1'b0; inInst = '0; inExtop = '0; inTag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov32", ov32, 1'b0);
    chk("rst_rdy32", rdy32, 1'b1);
    chk("rst_imm32", imm32o, 32'h0);
    chk("rst_ill32", ill32o, 1'b0);
    chk("rst_tag32", tag32o, 32'h0);
    chk("rst_ov64", ov64, 1'b0);
    chk("rst_rdy64", rdy64, 1'b1);
    chk("rst_imm64", imm64o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: accepted in cycle N, valid in cycle N+1.
    outReady = 1'b1;
    sendVec(0, 32'h100);
    @(negedge clk);
    chk("lat_ov32", ov32, 1'b1);
    chk("lat_tag32", tag32o, 32'h100);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) sendVec(i, 32'h200 + i);
    idle(3);
    chk("dir_drain", q.size(), 0);

    // Backpressure: two accepted, third held.
    outReady = 1'b0;
    sendVec(0, 32'd1);
    sendVec(0, 32'd2);
    inValid = 1'b1;
    inInst  = vecs[0].inst;
    inExtop = vecs[0].op;
    inTag   = 32'd3;
    repeat (2) begin
      @(negedge clk);
      chk("bp_rdy_lo", rdy32, 1'b0);
      chk("bp_hold_tag", tag32o, 32'd1);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(negedge clk);
    chk("bp_t1", tag32o, 32'd1);
    chk("bp_rdy_t1", rdy32, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_t2", tag32o, 32'd2);
    chk("bp_rdy_t2", rdy32, 1'b1);
    q.push_back(mkExp(0, 32'd3));
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    chk("bp_t3_valid", ov32, 1'b1);
    chk("bp_t3", tag32o, 32'd3);
    @(posedge clk); #1;
    idle(2);

    // Flush with both entries full.
    outReady = 1'b0;
    sendVec(1, 32'h10);
    sendVec(2, 32'h11);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    @(negedge clk);
    chk("fl_ov32", ov32, 1'b0);
    chk("fl_rdy32", rdy32, 1'b1);
    chk("fl_ov64", ov64, 1'b0);
    @(posedge clk); #1;

    // Item offered while flushing must vanish.
    sendVec(1, 32'h20);
    flush   = 1'b1;
    inValid = 1'b1;
    inTag   = 32'h21;
    @(posedge clk); #1;
    flush   = 1'b0;
    inValid = 1'b0;
    q.delete();
    outReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fl_drop", ov32, 1'b0);
      @(posedge clk); #1;
    end

    // Reset with both entries full.
    outReady = 1'b0;
    sendVec(5, 32'h30);
    sendVec(6, 32'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mr_ov32", ov32, 1'b0);
    chk("mr_rdy32", rdy32, 1'b1);
    chk("mr_imm32", imm32o, 32'h0);
    chk("mr_tag32", tag32o, 32'h0);
    chk("mr_imm64", imm64o, 64'h0);
    @(posedge clk); #1;

    // Random stream with random backpressure.
    randReady = 1;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] inst;
      logic [3:0]  op;
      logic [64:0] r32, r64;
      exp_t e;
      inst = $urandom;
      if ($urandom_range(0, 9) == 0)
        op = 4'($urandom_range(8, 15));
      else
        op = 4'($urandom_range(0, 7));
      r32 = refDecode(inst, op, 1'b1);
      r64 = refDecode(inst, op, 1'b0);
      e.imm32 = r32[31:0];
      e.ill32 = r32[64];
      e.imm64 = r64[63:0];
      e.ill64 = r64[64];
      e.tag   = 32'd1000 + 32'(i);
      send(inst, op, e.tag, e);
    end
    randReady = 0;
    @(posedge clk); #2;
    outReady = 1'b1;
    for (int n = 0; n < 50 && q.size() != 0; n++)
      @(posedge clk);
    @(negedge clk);
    chk("rand_drain", q.size(), 0);
    chk("final_ov32", ov32, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
